// File: rtl/sap_pkg.sv
// Shared SAP memory definitions: sequencer states and default bus widths.
package sap_pkg;

  localparam int unsigned SAP_ADDR_WIDTH = 4;
  localparam int unsigned SAP_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2
  } sap_state_e;

endpackage

// File: rtl/sap_ram_array.sv
// SAP RAM storage: single write port plus registered read-first read port.
// Build option SAP_RAM_PARITY_EN stores an even-parity bit per word and adds par_err_o.
module sap_ram_array
  import sap_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = SAP_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = SAP_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
`ifdef SAP_RAM_PARITY_EN
  ,
  output logic                  par_err_o
`endif
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
`ifdef SAP_RAM_PARITY_EN
  localparam int unsigned STORE_WIDTH = DATA_WIDTH + 1;
`else
  localparam int unsigned STORE_WIDTH = DATA_WIDTH;
`endif

  logic [STORE_WIDTH-1:0] mem_q [DEPTH];
  logic [STORE_WIDTH-1:0] wword;
  logic [STORE_WIDTH-1:0] rword;
  logic [DATA_WIDTH-1:0]  rdata_q;

  // Parity bit (when present) sits above the data so the whole word XORs to zero.
  always_comb begin
`ifdef SAP_RAM_PARITY_EN
    wword = {^wdata_i, wdata_i};
`else
    wword = wdata_i;
`endif
    rword = mem_q[raddr_i];
  end

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wword;
    end
  end

  // Read samples the array before this edge's write lands, giving read-first behaviour.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= rword[DATA_WIDTH-1:0];
    end
  end

  assign rdata_o = rdata_q;

`ifdef SAP_RAM_PARITY_EN
  logic par_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      par_err_q <= 1'b0;
    end else begin
      par_err_q <= re_i & (^rword);
    end
  end

  assign par_err_o = par_err_q;
`endif

endmodule

// File: rtl/sap_ram_loader.sv
// SAP main memory front end: power-on clear, handshaked program load, then CPU port.
// Build option SAP_RAM_PARITY_EN adds per-word parity and the par_err output.
module sap_ram_loader
  import sap_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = SAP_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = SAP_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_en,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  input  logic [DATA_WIDTH-1:0] ld_data,
  input  logic                  ld_last,
  output logic [ADDR_WIDTH:0]   ld_count,
  output logic                  mem_ready,
  input  logic                  rw,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out
`ifdef SAP_RAM_PARITY_EN
  ,
  output logic                  par_err
`endif
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  sap_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_ptr_q, clr_ptr_d;
  logic [ADDR_WIDTH:0]   ld_count_q, ld_count_d;
  logic                  ld_ready_q, ld_ready_d;
  logic                  mem_ready_q, mem_ready_d;

  logic                  we_c;
  logic [ADDR_WIDTH-1:0] waddr_c;
  logic [DATA_WIDTH-1:0] wdata_c;
  logic                  re_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_CLEAR;
      clr_ptr_q   <= '0;
      ld_count_q  <= '0;
      ld_ready_q  <= 1'b0;
      mem_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_ptr_q   <= clr_ptr_d;
      ld_count_q  <= ld_count_d;
      ld_ready_q  <= ld_ready_d;
      mem_ready_q <= mem_ready_d;
    end
  end

  // Sequencer: picks the single write source for the array in each state.
  always_comb begin
    state_d    = state_q;
    clr_ptr_d  = clr_ptr_q;
    ld_count_d = ld_count_q;
    we_c       = 1'b0;
    waddr_c    = clr_ptr_q;
    wdata_c    = '0;
    re_c       = 1'b0;

    case (state_q)
      ST_CLEAR: begin
        we_c      = 1'b1;
        clr_ptr_d = clr_ptr_q + ADDR_WIDTH'(1);
        if (clr_ptr_q == ADDR_WIDTH'(DEPTH - 1)) begin
          state_d = load_en ? ST_LOAD : ST_RUN;
        end
      end
      ST_LOAD: begin
        waddr_c = ld_count_q[ADDR_WIDTH-1:0];
        wdata_c = ld_data;
        if (ld_valid && ld_ready_q) begin
          we_c       = 1'b1;
          ld_count_d = ld_count_q + (ADDR_WIDTH + 1)'(1);
          // Leaving on a full memory prevents the count from wrapping onto address 0.
          if (ld_last || (ld_count_q == (ADDR_WIDTH + 1)'(DEPTH - 1))) begin
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        we_c    = rw;
        waddr_c = addr;
        wdata_c = data_in;
        re_c    = 1'b1;
      end
      default: begin
        state_d = ST_CLEAR;
      end
    endcase

    ld_ready_d  = (state_d == ST_LOAD);
    mem_ready_d = (state_d == ST_RUN);
  end

  sap_ram_array #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_array (
    .clk       (clk),
    .rst       (rst),
    .we_i      (we_c),
    .waddr_i   (waddr_c),
    .wdata_i   (wdata_c),
    .re_i      (re_c),
    .raddr_i   (addr),
    .rdata_o   (data_out)
`ifdef SAP_RAM_PARITY_EN
    ,
    .par_err_o (par_err)
`endif
  );

  assign ld_ready  = ld_ready_q;
  assign ld_count  = ld_count_q;
  assign mem_ready = mem_ready_q;

endmodule
